// File: rtl/l2_cfi_instr_responder_pkg.sv
// Shared types and constants for the L2 CFI instruction responder.
`ifndef CFI_INSTR_WIDTH_DEF
`define CFI_INSTR_WIDTH_DEF 33
`endif

package l2_cfi_pkg;

    // 32-bit instruction plus one CFI tag bit
    localparam int CFI_INSTR_WIDTH_DEF = `CFI_INSTR_WIDTH_DEF;

    // Deepest SRAM read latency the response pipeline supports
    localparam int MAX_MEM_LATENCY = 3;

    // One in-flight response: valid marks an occupied slot, err selects an r_opc response
    typedef struct packed {
        logic valid;
        logic err;
    } resp_slot_t;

endpackage

// File: rtl/l2_cfi_instr_responder_if.sv
// Initiator-side XBAR_TCDM_BUS_CFI instruction bus (req/gnt + r_valid response).
interface l2_cfi_instr_if
    import l2_cfi_pkg::*;
#(
    parameter int W = CFI_INSTR_WIDTH_DEF
);
    logic          req;
    logic [31:0]   add;
    logic          wen;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          gnt;
    logic          r_valid;
    logic [W-1:0]  r_rdata;
    logic          r_opc;

    modport master (
        output req, add, wen, wdata, be,
        input  gnt, r_valid, r_rdata, r_opc
    );

    modport slave (
        input  req, add, wen, wdata, be,
        output gnt, r_valid, r_rdata, r_opc
    );
endinterface

// File: rtl/l2_cfi_resp_pipe.sv
// Fixed-depth {valid,err} shift register; one slot per accepted request, in order.
module l2_cfi_resp_pipe
    import l2_cfi_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  resp_slot_t in_i,
    output resp_slot_t out_o
);

    resp_slot_t [DEPTH-1:0] slot_q, slot_d;

    // Shift one stage per cycle; a new slot enters at stage 0 every cycle
    always_comb begin
        slot_d    = slot_q;
        slot_d[0] = in_i;
        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i-1];
        end
    end

    // Reset drops every in-flight response
    always_ff @(posedge clk_i) begin
        if (!rst_ni) slot_q <= '0;
        else         slot_q <= slot_d;
    end

    assign out_o = slot_q[DEPTH-1];

endmodule

// File: rtl/l2_cfi_instr_responder.sv
// Target endpoint of the CFI instruction bus, serving fetches from one L2 SRAM bank.
// Errors travel through the same fixed-latency pipeline as reads, so responses stay in order.
module l2_cfi_instr_responder
    import l2_cfi_pkg::*;
#(
    parameter int          CFI_INSTR_WIDTH = CFI_INSTR_WIDTH_DEF,
    parameter int          MEM_ADDR_WIDTH  = 14,
    parameter int          MEM_LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR       = 32'h1C00_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    l2_cfi_instr_if.slave              bus,
    output logic                       mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic                       mem_gnt_i,
    input  logic [CFI_INSTR_WIDTH-1:0] mem_rdata_i,
    output logic [7:0]                 err_cnt_o,
    output logic [31:0]                err_addr_o
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
        $error("l2_cfi_instr_responder: MEM_LATENCY must be 1..3");
    end

    logic [31:0] off;
    logic        out_of_range;
    logic        req_err;
    logic        gnt;
    logic        r_valid;
    resp_slot_t  pipe_in, pipe_out;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        unused_ok;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range
    assign off          = bus.add - BASE_ADDR;
    assign out_of_range = |off[31:MEM_ADDR_WIDTH+2];
    assign req_err      = ~bus.wen | (bus.add[1:0] != 2'b00) | out_of_range;

    // Errors never touch the SRAM and are granted without waiting on the bank
    assign mem_req_o  = rst_ni & bus.req & ~req_err;
    assign mem_addr_o = off[MEM_ADDR_WIDTH+1:2];
    assign gnt        = rst_ni & bus.req & (req_err | mem_gnt_i);
    assign bus.gnt    = gnt;

    assign pipe_in = '{valid: gnt, err: gnt & req_err};

    l2_cfi_resp_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_i   (pipe_in),
        .out_o  (pipe_out)
    );

    // Read data is only forwarded for a live read slot; everything else is zero
    assign r_valid     = rst_ni & pipe_out.valid;
    assign bus.r_valid = r_valid;
    assign bus.r_opc   = r_valid & pipe_out.err;
    assign bus.r_rdata = (r_valid & ~pipe_out.err) ? mem_rdata_i : '0;

    // Count errors as they leave the pipeline; remember the newest erroring address at grant
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (r_valid && pipe_out.err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        if (gnt && req_err) err_addr_d = bus.add;
    end

    // Error bookkeeping registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

    // Write data, byte enables and the byte offset within a word are not used by a read-only target
    assign unused_ok = ^{bus.wdata, bus.be, off[1:0]};

endmodule
